// File: rtl/bp_be_rec_to_fp_pipe_pkg.sv
// Shared constants for the recoded-to-IEEE converter pipe: format widths, SP/DP bias
// adjust, recoded special exponent codes and the RISC-V canonical NaN patterns.
package bp_be_rec_to_fp_pipe_pkg;

  localparam int dword_width_gp  = 64;
  localparam int word_width_gp   = 32;
  localparam int dp_exp_width_gp = 11;
  localparam int dp_sig_width_gp = 53;
  localparam int sp_exp_width_gp = 8;
  localparam int sp_sig_width_gp = 24;

  // Recoded formats carry one extra exponent bit over IEEE.
  localparam int dp_rec_width_gp = dp_exp_width_gp + dp_sig_width_gp + 1;

  localparam int dp_min_norm_exp_gp = (1 << (dp_exp_width_gp - 1)) + 2;
  localparam int sp_min_norm_exp_gp = (1 << (sp_exp_width_gp - 1)) + 2;

  localparam int sp_bias_adj_gp = (1 << sp_exp_width_gp) - (1 << dp_exp_width_gp);

  localparam logic [2:0] rec_exp_zero_gp = 3'b000;
  localparam logic [2:0] rec_exp_inf_gp  = 3'b110;
  localparam logic [2:0] rec_exp_nan_gp  = 3'b111;

  localparam logic [63:0] dp_canon_nan_gp       = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] sp_canon_nan_boxed_gp = 64'hffff_ffff_7fc0_0000;

  typedef struct packed {
    logic        sign;
    logic [11:0] exp;
    logic [51:0] fract;
  } dp_rec_s;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [22:0] fract;
  } sp_rec_s;

  function automatic logic is_special_code(input logic [2:0] code);
    return (code == rec_exp_zero_gp) || (code == rec_exp_inf_gp) || (code == rec_exp_nan_gp);
  endfunction

endpackage

// File: rtl/bp_be_rec_to_fp_pipe_if.sv
// Front/back-end bundle of the recoded-to-IEEE pipe. The pipe side uses modport slave,
// the producer/consumer side uses modport master.
interface bp_be_rec_to_fp_pipe_if
  #(parameter int lanes_p     = 2,
    parameter int tag_width_p = 5);

  import bp_be_rec_to_fp_pipe_pkg::*;

  // Handshakes: an entry enters when v_i & ready_o at a clock edge (ready_o may depend
  // combinationally on yumi_i); an entry leaves when yumi_i, which is only legal while v_o.
  logic                                 v_i;
  logic                                 ready_o;
  logic [lanes_p*dp_rec_width_gp-1:0]   rec_i;
  logic [lanes_p-1:0]                   sp_not_dp_i;
  logic [tag_width_p-1:0]               tag_i;
  logic                                 v_o;
  logic                                 yumi_i;
  logic [lanes_p*dword_width_gp-1:0]    raw_o;
  logic [tag_width_p-1:0]               tag_o;

  modport master (
    output v_i, rec_i, sp_not_dp_i, tag_i, yumi_i,
    input  ready_o, v_o, raw_o, tag_o
  );

  modport slave (
    input  v_i, rec_i, sp_not_dp_i, tag_i, yumi_i,
    output ready_o, v_o, raw_o, tag_o
  );

endinterface

// File: rtl/bp_be_rec_to_fp_lane.sv
// Combinational single-lane recoded-DP to IEEE converter (DP, or SP NaN-boxed).
// Optional macro BP_BE_REC_TO_FP_CANON_NAN_EN replaces any NaN result with the canonical NaN.
module bp_be_rec_to_fp_lane
  import bp_be_rec_to_fp_pipe_pkg::*;
  (
    input  logic [dp_rec_width_gp-1:0] rec,
    input  logic                       sp_not_dp,
    output logic [dword_width_gp-1:0]  raw
  );

  dp_rec_s dp_rec;
  sp_rec_s sp_rec;
  assign dp_rec = rec;

  logic        dp_zero, dp_special, dp_nan, dp_inf, dp_subnormal;
  logic [53:0] dp_sig;
  logic [5:0]  dp_dist;
  logic [10:0] dp_exp_out;
  logic [51:0] dp_fract_out;
  logic [63:0] dp_raw;

  assign dp_zero      = (dp_rec.exp[11:9] == 3'b000);
  assign dp_special   = (dp_rec.exp[11:10] == 2'b11);
  assign dp_nan       = dp_special & dp_rec.exp[9];
  assign dp_inf       = dp_special & ~dp_rec.exp[9];
  assign dp_sig       = {1'b0, ~dp_zero, dp_rec.fract};
  assign dp_subnormal = (dp_rec.exp < 12'(dp_min_norm_exp_gp));
  assign dp_dist      = 6'(12'(dp_min_norm_exp_gp - 1) - dp_rec.exp);
  assign dp_exp_out   = (dp_subnormal ? 11'd0 : 11'(dp_rec.exp - 12'(dp_min_norm_exp_gp - 1)))
                      | ((dp_nan | dp_inf) ? 11'h7ff : 11'd0);
  assign dp_fract_out = dp_subnormal ? 52'((dp_sig >> 1) >> dp_dist)
                      : (dp_inf ? 52'd0 : dp_sig[51:0]);
  assign dp_raw       = {dp_rec.sign, dp_exp_out, dp_fract_out};

  // Narrow to recoded SP: rebias the exponent, but keep the zero/inf/NaN code bits intact.
  logic [2:0] exp_code;
  logic [8:0] sp_exp_adj;

  assign exp_code     = dp_rec.exp[11-:3];
  assign sp_exp_adj   = dp_rec.exp[8:0] + 9'(sp_bias_adj_gp);
  assign sp_rec.sign  = dp_rec.sign;
  assign sp_rec.exp   = is_special_code(exp_code) ? {exp_code, sp_exp_adj[5:0]} : sp_exp_adj;
  assign sp_rec.fract = dp_rec.fract[51:29];

  logic        sp_zero, sp_special, sp_nan, sp_inf, sp_subnormal;
  logic [24:0] sp_sig;
  logic [4:0]  sp_dist;
  logic [7:0]  sp_exp_out;
  logic [22:0] sp_fract_out;
  logic [63:0] sp_boxed;

  assign sp_zero      = (sp_rec.exp[8:6] == 3'b000);
  assign sp_special   = (sp_rec.exp[8:7] == 2'b11);
  assign sp_nan       = sp_special & sp_rec.exp[6];
  assign sp_inf       = sp_special & ~sp_rec.exp[6];
  assign sp_sig       = {1'b0, ~sp_zero, sp_rec.fract};
  assign sp_subnormal = (sp_rec.exp < 9'(sp_min_norm_exp_gp));
  assign sp_dist      = 5'(9'(sp_min_norm_exp_gp - 1) - sp_rec.exp);
  assign sp_exp_out   = (sp_subnormal ? 8'd0 : 8'(sp_rec.exp - 9'(sp_min_norm_exp_gp - 1)))
                      | ((sp_nan | sp_inf) ? 8'hff : 8'd0);
  assign sp_fract_out = sp_subnormal ? 23'((sp_sig >> 1) >> sp_dist)
                      : (sp_inf ? 23'd0 : sp_sig[22:0]);
  assign sp_boxed     = {{word_width_gp{1'b1}}, sp_rec.sign, sp_exp_out, sp_fract_out};

`ifdef BP_BE_REC_TO_FP_CANON_NAN_EN
  assign raw = sp_not_dp ? (sp_nan ? sp_canon_nan_boxed_gp : sp_boxed)
                         : (dp_nan ? dp_canon_nan_gp : dp_raw);
`else
  assign raw = sp_not_dp ? sp_boxed : dp_raw;
`endif

endmodule

// File: rtl/bp_be_rec_to_fp_pipe.sv
// Multi-lane elastic pipeline converting recoded DP operands to raw IEEE bits.
// Optional macro BP_BE_REC_TO_FP_CANON_NAN_EN (applied inside each lane) canonicalises NaNs.
module bp_be_rec_to_fp_pipe
  import bp_be_rec_to_fp_pipe_pkg::*;
  #(parameter int lanes_p     = 2,
    parameter int stages_p    = 2,
    parameter int tag_width_p = 5)
  (
    input  logic                     clk_i,
    input  logic                     reset_i,
    bp_be_rec_to_fp_pipe_if.slave    io
  );

  localparam int raw_width_lp = lanes_p * dword_width_gp;

  logic [raw_width_lp-1:0] conv_raw;

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    bp_be_rec_to_fp_lane lane (
      .rec       (io.rec_i[l*dp_rec_width_gp +: dp_rec_width_gp]),
      .sp_not_dp (io.sp_not_dp_i[l]),
      .raw       (conv_raw[l*dword_width_gp +: dword_width_gp])
    );
  end

  logic [stages_p-1:0]     v_r;
  logic [raw_width_lp-1:0] raw_r  [stages_p];
  logic [tag_width_p-1:0]  tag_r  [stages_p];

  logic [stages_p-1:0]     in_v;
  logic [raw_width_lp-1:0] in_raw [stages_p];
  logic [tag_width_p-1:0]  in_tag [stages_p];

  for (genvar k = 0; k < stages_p; k++) begin : g_stage_in
    if (k == 0) begin : g_head
      assign in_v[0]   = io.v_i;
      assign in_raw[0] = conv_raw;
      assign in_tag[0] = io.tag_i;
    end else begin : g_body
      assign in_v[k]   = v_r[k-1];
      assign in_raw[k] = raw_r[k-1];
      assign in_tag[k] = tag_r[k-1];
    end
  end

  // A stage may load when it, or any stage downstream of it, is empty, or the consumer
  // takes the tail entry this cycle; written flat so no bit depends on another bit.
  logic [stages_p-1:0] stage_ready;

  always_comb begin
    for (int k = 0; k < stages_p; k++) begin
      stage_ready[k] = io.yumi_i;
      for (int j = 0; j < stages_p; j++) begin
        if (j >= k && !v_r[j]) stage_ready[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r <= '0;
      for (int k = 0; k < stages_p; k++) begin
        raw_r[k] <= '0;
        tag_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < stages_p; k++) begin
        if (stage_ready[k]) begin
          v_r[k] <= in_v[k];
          if (in_v[k]) begin
            raw_r[k] <= in_raw[k];
            tag_r[k] <= in_tag[k];
          end
        end
      end
    end
  end

  assign io.ready_o = stage_ready[0];
  assign io.v_o     = v_r[stages_p-1];
  assign io.raw_o   = raw_r[stages_p-1];
  assign io.tag_o   = tag_r[stages_p-1];

`ifndef SYNTHESIS
  yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) io.yumi_i |-> io.v_o);
`endif

endmodule

// File: tb/tb_bp_be_rec_to_fp_pipe.sv
// Scoreboard bench for bp_be_rec_to_fp_pipe: directed operand table with hand-computed results.
module tb_bp_be_rec_to_fp_pipe;
  import bp_be_rec_to_fp_pipe_pkg::*;

  localparam int lanes_p     = 2;
  localparam int stages_p    = 2;
  localparam int tag_width_p = 5;
  localparam int W           = tag_width_p + lanes_p * dword_width_gp;
  localparam int n_tbl       = 11;

`ifdef BP_BE_REC_TO_FP_CANON_NAN_EN
  localparam logic [63:0] dp_snan_exp = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] sp_nan_exp  = 64'hffff_ffff_7fc0_0000;
`else
  localparam logic [63:0] dp_snan_exp = 64'h7ff0_0000_0000_0001;
  localparam logic [63:0] sp_nan_exp  = 64'hffff_ffff_ffc0_0001;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_be_rec_to_fp_pipe_if #(.lanes_p(lanes_p), .tag_width_p(tag_width_p)) io ();

  bp_be_rec_to_fp_pipe #(.lanes_p(lanes_p), .stages_p(stages_p), .tag_width_p(tag_width_p)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (io)
  );

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int yumi_mode = 0;

  logic [64:0] vec_rec [n_tbl];
  logic        vec_sp  [n_tbl];
  logic [63:0] vec_raw [n_tbl];

  function automatic void chk(string name, logic [W-1:0] got, logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  task automatic set_vec(int i, logic [64:0] r, logic s, logic [63:0] x);
    vec_rec[i] = r;
    vec_sp[i]  = s;
    vec_raw[i] = x;
  endtask

  // driver tasks
  task automatic drive(int tag, int i0, int i1);
    io.rec_i       = {vec_rec[i1], vec_rec[i0]};
    io.sp_not_dp_i = {vec_sp[i1], vec_sp[i0]};
    io.tag_i       = 5'(tag);
  endtask

  task automatic push_exp(int tag, int i0, int i1);
    exp_q.push_back({5'(tag), vec_raw[i1], vec_raw[i0]});
  endtask

  task automatic send(int tag, int i0, int i1);
    int c = 0;
    drive(tag, i0, i1);
    io.v_i = 1'b1;
    @(negedge clk);
    while (!io.ready_o && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (io.ready_o) push_exp(tag, i0, i1);
    else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout tag=%0d got=ready_low want=accept", tag);
    end
    @(posedge clk);
    #1;
    io.v_i = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int c = 0;
    while ((exp_q.size() != 0 || io.v_o) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain", W'(exp_q.size()), W'(0));
  endtask

  // consumer: yumi only ever follows a registered v_o
  initial begin
    io.yumi_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (yumi_mode)
        1:       io.yumi_i = io.v_o;
        2:       io.yumi_i = io.v_o && ($urandom_range(0, 3) != 0);
        default: io.yumi_i = 1'b0;
      endcase
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && io.v_o && io.yumi_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out got=%h want=none", {io.tag_o, io.raw_o});
      end else begin
        chk("out", {io.tag_o, io.raw_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int lat;
    int accepted;
    int tag;

    set_vec(0,  {1'b0, 12'h800, 52'h0},               1'b0, 64'h3ff0_0000_0000_0000);
    set_vec(1,  {1'b0, 12'h800, 52'h0},               1'b1, 64'hffff_ffff_3f80_0000);
    set_vec(2,  {1'b1, 12'h000, 52'h0},               1'b1, 64'hffff_ffff_8000_0000);
    set_vec(3,  {1'b0, 12'hc00, 52'h0},               1'b0, 64'h7ff0_0000_0000_0000);
    set_vec(4,  {1'b0, 12'he00, 52'h1},               1'b0, dp_snan_exp);
    set_vec(5,  {1'b1, 12'h801, 52'h4_0000_0000_0000}, 1'b0, 64'hc004_0000_0000_0000);
    set_vec(6,  {1'b1, 12'h801, 52'h4_0000_0000_0000}, 1'b1, 64'hffff_ffff_c020_0000);
    set_vec(7,  {1'b0, 12'h400, 52'h0},               1'b0, 64'h0004_0000_0000_0000);
    set_vec(8,  {1'b1, 12'he00, 52'h8_0000_2000_0001}, 1'b1, sp_nan_exp);
    set_vec(9,  {1'b0, 12'h780, 52'h0},               1'b1, 64'hffff_ffff_0020_0000);
    set_vec(10, {1'b0, 12'h000, 52'h0},               1'b0, 64'h0000_0000_0000_0000);

    io.v_i = 1'b0;
    drive(0, 10, 10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_v_o",     W'(io.v_o),    W'(0));
    chk("rst_raw_o",   W'(io.raw_o),  W'(0));
    chk("rst_tag_o",   W'(io.tag_o),  W'(0));
    chk("rst_ready_o", W'(io.ready_o), W'(1));

    // single entry latency, lane 0 DP 1.0 and lane 1 SP 1.0
    yumi_mode = 1;
    @(posedge clk);
    #1;
    drive(1, 0, 1);
    io.v_i = 1'b1;
    @(negedge clk);
    chk("t1_ready", W'(io.ready_o), W'(1));
    push_exp(1, 0, 1);
    @(posedge clk);
    #1;
    io.v_i = 1'b0;
    lat = 1;
    while (!io.v_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", W'(lat), W'(stages_p));
    wait_drain(50);

    // every table entry, lanes mixing DP and SP
    for (int i = 0; i < n_tbl; i++) send(i + 8, i, (i + 5) % n_tbl);
    wait_drain(100);

    // fill with the consumer stalled
    yumi_mode = 0;
    @(posedge clk);
    #1;
    tag = 0;
    accepted = 0;
    drive(0, 0, 3);
    io.v_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (io.ready_o) begin
        push_exp(tag, tag % n_tbl, (tag + 3) % n_tbl);
        accepted++;
      end
      @(posedge clk);
      #1;
      if (accepted == tag + 1) begin
        tag++;
        drive(tag, tag % n_tbl, (tag + 3) % n_tbl);
      end
    end
    @(negedge clk);
    chk("fill_accepts", W'(accepted),   W'(stages_p));
    chk("full_ready",   W'(io.ready_o), W'(0));
    chk("full_v_o",     W'(io.v_o),     W'(1));
    chk("full_hold",    W'(io.tag_o),   W'(0));

    // release: one in, one out every cycle with no gap
    yumi_mode = 1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int t = stages_p; t <= stages_p + 2; t++) send(t, t % n_tbl, (t + 3) % n_tbl);
      end
      begin
        for (int c = 0; c < stages_p + 3; c++) begin
          @(negedge clk);
          chk("no_gap_v_o", W'(io.v_o), W'(1));
        end
      end
    join
    wait_drain(50);

    // reset with a full pipe flushes everything
    yumi_mode = 0;
    send(20, 3, 4);
    send(21, 8, 9);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_v_o",     W'(io.v_o),    W'(0));
    chk("flush_ready_o", W'(io.ready_o), W'(1));
    yumi_mode = 1;
    repeat (8) begin
      @(negedge clk);
      chk("flush_quiet", W'(io.v_o), W'(0));
    end
    @(posedge clk);
    #1;
    send(7, 5, 6);
    wait_drain(50);

    // random handshakes over the directed table
    yumi_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(i, int'($urandom_range(0, n_tbl - 1)), int'($urandom_range(0, n_tbl - 1)));
    end
    wait_drain(2000);

    chk("final_queue", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
